// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared FSM state type and counter-width helper for the bit-serial adder
package serial_add_pkg;
   typedef enum logic [1:0] {IDLE, PH0, PH1, DONE} state_t;
   function automatic int cnt_w(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction
endpackage

// File: rtl/half_adder_cell.sv
// half_adder_cell: the single shared AND/XOR gate pair
module half_adder_cell (
   input  logic a,
   input  logic b,
   output logic and_o,
   output logic xor_o
);
   assign and_o = a & b;
   assign xor_o = a ^ b;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: two-phase bit-serial ripple adder on one half-adder cell; SERIAL_ADD_SUB_EN adds in_sub (A-B)
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             in_sub,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_carry
);
   localparam int CNT_W = cnt_w(WIDTH);
   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic [CNT_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d, ps_q, ps_d, c1_q, c1_d;
   logic               in_ready_q, out_valid_q;
   logic               cell_a, cell_b, cell_and, cell_xor, sub;
`ifdef SERIAL_ADD_SUB_EN
   assign sub = in_sub;
`else
   assign sub = 1'b0;
`endif
   assign cell_a = (state_q == PH0) ? a_q[idx_q] : ps_q;
   assign cell_b = (state_q == PH0) ? b_q[idx_q] : carry_q;
   half_adder_cell u_cell (
      .a     (cell_a),
      .b     (cell_b),
      .and_o (cell_and),
      .xor_o (cell_xor)
   );
   // next-state: sequence PH0/PH1 per bit, latching the cell outputs each phase
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      ps_d    = ps_q;
      c1_d    = c1_q;
      case (state_q)
         IDLE: if (in_valid && in_ready_q) begin
            a_d     = in_a;
            b_d     = sub ? ~in_b : in_b;
            carry_d = sub;
            idx_d   = '0;
            state_d = PH0;
         end
         PH0: begin
            ps_d    = cell_xor;
            c1_d    = cell_and;
            state_d = PH1;
         end
         PH1: begin
            sum_d[idx_q] = cell_xor;
            carry_d      = c1_q | cell_and;
            if (idx_q == CNT_W'(WIDTH - 1)) state_d = DONE;
            else begin
               idx_d   = idx_q + 1'b1;
               state_d = PH0;
            end
         end
         default: state_d = out_ready ? IDLE : DONE;
      endcase
   end
   // state register; handshake outputs are registered from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         ps_q        <= 1'b0;
         c1_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         ps_q        <= ps_d;
         c1_q        <= c1_d;
         in_ready_q  <= (state_d == IDLE);
         out_valid_q <= (state_d == DONE);
      end
   end
   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = sum_q;
   assign out_carry = carry_q;
endmodule
